id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID->EX pipeline register directly downstream of the hazard unit. Captures decoded
//  operands/control from ID each cycle; inserts a bubble on load-use flush (Flush_EX),
//  kills the entry on branch redirect, and holds when EX is stalled.
//  Its rs/rd/control outputs feed the hazard unit's forwarding and load-use checks.
//  Saturating counters report inserted bubbles and branch kills.
// PARAMETERS
//  XLEN   32  data/PC width
//  CNT_W  16  width of each performance counter
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      asynchronous active-low reset
//  Flush_EX        in   1      load-use bubble request from hazard unit
//  flush_branch    in   1      branch/jump redirect: kill instruction entering EX
//  stall_EX        in   1      downstream multicycle stall: hold register contents
//  valid_ID        in   1      ID holds a real instruction
//  pc_ID           in   XLEN   PC of ID instruction
//  rs1_val_ID      in   XLEN   register file read data 1
//  rs2_val_ID      in   XLEN   register file read data 2
//  imm_ID          in   XLEN   sign-extended immediate
//  rs1n_ID         in   5      source register 1 number
//  rs2n_ID         in   5      source register 2 number
//  rdn_ID          in   5      destination register number
//  RegWrite_ID     in   1      writes rd
//  MemToReg_ID     in   1      load (result from memory)
//  MemWrite_ID     in   1      store
//  ALUSrc_ID       in   1      ALU operand 2 = imm
//  ALUOp_ID        in   4      ALU operation code
//  Branch_ID       in   1      conditional branch
//  Jump_ID         in   1      unconditional jump
//  valid_EX .. Jump_EX  out  same widths   registered copies of every *_ID input above
//  bubble_cnt      out  CNT_W  load-use bubbles inserted (saturating)
//  kill_cnt        out  CNT_W  valid instructions killed by flush_branch (saturating)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0, counters 0. Outputs are a bubble
//    (valid_EX=0, all control 0, rs1n/rs2n/rdn_EX=0) until first load after rst_n rises.
//  - Per rising edge, priority highest first:
//    1 flush_branch=1 : load bubble; overrides stall_EX and Flush_EX.
//    2 stall_EX=1     : hold all *_EX outputs; Flush_EX ignored this cycle.
//    3 Flush_EX=1     : load bubble.
//    4 else           : load all *_ID fields; valid_EX<=valid_ID.
//  - Bubble = valid_EX, RegWrite_EX, MemToReg_EX, MemWrite_EX, Branch_EX, Jump_EX,
//    ALUSrc_EX = 0; ALUOp_EX=0; rs1n_EX=rs2n_EX=rdn_EX=0 (x0 never forwards/stalls);
//    pc/values/imm_EX=0.
//  - Latency 1 cycle ID->EX. No combinational path input->output.
//  - Control for valid_ID=0 is loaded as-is in case 4 (ID bubble propagates);
//    upstream guarantees control=0 when valid_ID=0.
//  - bubble_cnt +1 only on edges where case 3 applies.
//  - kill_cnt +1 on case-1 edges where valid_ID=1 (instruction actually discarded).
//  - Both counters saturate at 2^CNT_W-1, never wrap; hold during stall_EX.
//  - rst_n asserted mid-operation: immediate clear regardless of clk; counters cleared.
// TESTING
//  - Reset: rst_n=0 mid-cycle with valid_EX=1 -> all outputs 0 before next edge.
//  - Normal: valid_ID=1, pc_ID=0x100, rdn_ID=5, RegWrite_ID=1 -> next edge
//    valid_EX=1, pc_EX=0x100, rdn_EX=5, RegWrite_EX=1.
//  - Load-use: Flush_EX=1 one cycle -> valid_EX=0, rdn_EX=0, MemToReg_EX=0,
//    bubble_cnt 0->1; next edge with Flush_EX=0 loads ID fields.
//  - Stall: stall_EX=1 and Flush_EX=1 for 3 cycles -> *_EX unchanged, bubble_cnt
//    unchanged.
//  - Branch: flush_branch=1 with stall_EX=1, valid_ID=1 -> bubble loaded,
//    kill_cnt +1; with valid_ID=0 -> bubble, kill_cnt unchanged.
//  - Saturation (CNT_W=2): 5 consecutive Flush_EX edges -> bubble_cnt 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with branch kill, load-use bubble insertion, stall hold
// and saturating bubble/kill performance counters.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Flush_EX,
  input  logic             flush_branch,
  input  logic             stall_EX,
  input  logic             valid_ID,
  input  logic [XLEN-1:0]  pc_ID,
  input  logic [XLEN-1:0]  rs1_val_ID,
  input  logic [XLEN-1:0]  rs2_val_ID,
  input  logic [XLEN-1:0]  imm_ID,
  input  logic [4:0]       rs1n_ID,
  input  logic [4:0]       rs2n_ID,
  input  logic [4:0]       rdn_ID,
  input  logic             RegWrite_ID,
  input  logic             MemToReg_ID,
  input  logic             MemWrite_ID,
  input  logic             ALUSrc_ID,
  input  logic [3:0]       ALUOp_ID,
  input  logic             Branch_ID,
  input  logic             Jump_ID,
  output logic             valid_EX,
  output logic [XLEN-1:0]  pc_EX,
  output logic [XLEN-1:0]  rs1_val_EX,
  output logic [XLEN-1:0]  rs2_val_EX,
  output logic [XLEN-1:0]  imm_EX,
  output logic [4:0]       rs1n_EX,
  output logic [4:0]       rs2n_EX,
  output logic [4:0]       rdn_EX,
  output logic             RegWrite_EX,
  output logic             MemToReg_EX,
  output logic             MemWrite_EX,
  output logic             ALUSrc_EX,
  output logic [3:0]       ALUOp_EX,
  output logic             Branch_EX,
  output logic             Jump_EX,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] kill_cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1_val;
  logic [XLEN-1:0]  r_rs2_val;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs1n;
  logic [4:0]       r_rs2n;
  logic [4:0]       r_rdn;
  logic             r_reg_write;
  logic             r_mem_to_reg;
  logic             r_mem_write;
  logic             r_alu_src;
  logic [3:0]       r_alu_op;
  logic             r_branch;
  logic             r_jump;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_kill_cnt;

  logic w_kill;
  logic w_hold;
  logic w_bubble;
  logic w_clear;

  always_comb begin
    w_kill   = flush_branch;
    w_hold   = !flush_branch && stall_EX;
    w_bubble = !flush_branch && !stall_EX && Flush_EX;
    w_clear  = w_kill || w_bubble;
  end

  // Bubble clears rs/rd numbers too so x0 never matches in forwarding/load-use checks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1_val    <= '0;
      r_rs2_val    <= '0;
      r_imm        <= '0;
      r_rs1n       <= '0;
      r_rs2n       <= '0;
      r_rdn        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= '0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
    end else if (w_clear) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1_val    <= '0;
      r_rs2_val    <= '0;
      r_imm        <= '0;
      r_rs1n       <= '0;
      r_rs2n       <= '0;
      r_rdn        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= '0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
    end else if (!w_hold) begin
      r_valid      <= valid_ID;
      r_pc         <= pc_ID;
      r_rs1_val    <= rs1_val_ID;
      r_rs2_val    <= rs2_val_ID;
      r_imm        <= imm_ID;
      r_rs1n       <= rs1n_ID;
      r_rs2n       <= rs2n_ID;
      r_rdn        <= rdn_ID;
      r_reg_write  <= RegWrite_ID;
      r_mem_to_reg <= MemToReg_ID;
      r_mem_write  <= MemWrite_ID;
      r_alu_src    <= ALUSrc_ID;
      r_alu_op     <= ALUOp_ID;
      r_branch     <= Branch_ID;
      r_jump       <= Jump_ID;
    end
  end

  // Kill counts only real instructions discarded, even when EX is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_kill_cnt   <= '0;
    end else begin
      if (w_bubble && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CntOne;
      end
      if (w_kill && valid_ID && (r_kill_cnt != '1)) begin
        r_kill_cnt <= r_kill_cnt + CntOne;
      end
    end
  end

  always_comb begin
    valid_EX    = r_valid;
    pc_EX       = r_pc;
    rs1_val_EX  = r_rs1_val;
    rs2_val_EX  = r_rs2_val;
    imm_EX      = r_imm;
    rs1n_EX     = r_rs1n;
    rs2n_EX     = r_rs2n;
    rdn_EX      = r_rdn;
    RegWrite_EX = r_reg_write;
    MemToReg_EX = r_mem_to_reg;
    MemWrite_EX = r_mem_write;
    ALUSrc_EX   = r_alu_src;
    ALUOp_EX    = r_alu_op;
    Branch_EX   = r_branch;
    Jump_EX     = r_jump;
    bubble_cnt  = r_bubble_cnt;
    kill_cnt    = r_kill_cnt;
  end

endmodule
